// File: rtl/pcm_word_packer.sv
// Packs pairs of PCM samples into FIFO words, flags frame ends and counts overflow drops.
// PCM_PACKER_DROP_CNT_EN builds the saturating drop counter; when undefined, drop_cnt is tied to 0.
module pcm_word_packer #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int FRAME_SAMPLES  = 80,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  input  logic                      srst_wr_n,
  input  logic                      smp_valid,
  input  logic [SAMPLE_WIDTH-1:0]   smp_data,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                      frame_done,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int CNT_W = (FRAME_SAMPLES > 2) ? $clog2(FRAME_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_SAMPLES - 1);

  localparam logic [0:0] ST_LOW  = 1'b0;
  localparam logic [0:0] ST_HIGH = 1'b1;

  logic [0:0]              state;
  logic [SAMPLE_WIDTH-1:0] held_data;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic                    pend_valid;
  logic                    pend_last;
  logic [CNT_W-1:0]        smp_cnt;

  logic word_done;
  logic smp_last;
  logic drop;

  assign word_done = smp_valid & (state == ST_HIGH);
  assign smp_last  = (smp_cnt == CNT_LAST);
  // A new word is only lost when the old one is stuck behind a full FIFO.
  assign drop      = word_done & pend_valid & fifo_full;

  assign fifo_wr_en   = pend_valid & ~fifo_full;
  assign fifo_wr_data = pend_data;
  assign frame_done   = fifo_wr_en & pend_last;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state      <= ST_LOW;
      held_data  <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      smp_cnt    <= '0;
      overflow   <= 1'b0;
    end else if (!srst_wr_n) begin
      state      <= ST_LOW;
      held_data  <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      smp_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (smp_valid) begin
        smp_cnt <= smp_last ? '0 : smp_cnt + CNT_W'(1);
        if (state == ST_LOW) begin
          held_data <= smp_data;
          state     <= ST_HIGH;
        end else begin
          state <= ST_LOW;
        end
      end

      if (word_done && !drop) begin
        pend_data  <= {smp_data, held_data};
        pend_valid <= 1'b1;
        pend_last  <= smp_last;
      end else if (fifo_wr_en) begin
        pend_valid <= 1'b0;
      end

      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

`ifdef PCM_PACKER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  // Saturating; a drop in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      drop_q <= '0;
    end else if (!srst_wr_n) begin
      drop_q <= '0;
    end else if (drop) begin
      if (ovf_clr)
        drop_q <= DROP_CNT_WIDTH'(1);
      else if (drop_q != '1)
        drop_q <= drop_q + DROP_CNT_WIDTH'(1);
    end else if (ovf_clr) begin
      drop_q <= '0;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pcm_word_packer.sv
// Directed bench for pcm_word_packer: pairing, framing, backpressure, drop/clear, resets, saturation.
module tb_pcm_word_packer;

`ifdef PCM_PACKER_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        srst_wr_n;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        fifo_full;
  logic        ovf_clr;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        frame_done;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        s_wr_en;
  logic [31:0] s_wr_data;
  logic        s_frame_done;
  logic        s_overflow;
  logic [1:0]  s_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int full_viol = 0;

  logic        o_wr;
  logic [31:0] o_data;
  logic        o_fd;

  pcm_word_packer dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .srst_wr_n(srst_wr_n),
    .smp_valid(smp_valid), .smp_data(smp_data), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .frame_done(frame_done),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  pcm_word_packer #(.DROP_CNT_WIDTH(2)) dut_sat (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .srst_wr_n(srst_wr_n),
    .smp_valid(smp_valid), .smp_data(smp_data), .fifo_full(fifo_full),
    .fifo_wr_en(s_wr_en), .fifo_wr_data(s_wr_data), .frame_done(s_frame_done),
    .overflow(s_overflow), .ovf_clr(ovf_clr), .drop_cnt(s_drop_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, capture outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic full, input logic clr);
    smp_valid = v;
    smp_data  = d;
    fifo_full = full;
    ovf_clr   = clr;
    #2;
    o_wr   = fifo_wr_en;
    o_data = fifo_wr_data;
    o_fd   = frame_done;
    if ((full && fifo_wr_en) || (full && s_wr_en)) full_viol++;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic sreset();
    srst_wr_n = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    srst_wr_n = 1'b1;
  endtask

  task automatic run_frame(input logic [15:0] base, input logic [15:0] s0, input logic [15:0] s1,
                           output int n_wr, output int n_fd, output int fd_idx,
                           output logic [31:0] fd_data, output logic [31:0] first_data);
    n_wr = 0; n_fd = 0; fd_idx = 0; fd_data = '0; first_data = '0;
    for (int i = 0; i < 82; i++) begin
      logic [15:0] s;
      s = (i == 0) ? s0 : (i == 1) ? s1 : base + 16'(i);
      cyc(i < 80, s, 1'b0, 1'b0);
      if (o_wr) begin
        n_wr++;
        if (n_wr == 1) first_data = o_data;
      end
      if (o_fd) begin
        n_fd++;
        fd_idx  = n_wr;
        fd_data = o_data;
      end
    end
  endtask

  int n_wr, n_fd, fd_idx;
  logic [31:0] fd_data, first_data;

  initial begin
    rst_wr_n = 1'b0; srst_wr_n = 1'b1;
    smp_valid = 1'b0; smp_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk_wr);
    #1;
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    rst_wr_n = 1'b1;

    // Pairing
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    chk("pair_wr_after_lo", {31'b0, o_wr}, 32'd0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("pair_wr_at_hi", {31'b0, o_wr}, 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pair_wr_en", {31'b0, o_wr}, 32'd1);
    chk("pair_wr_data", o_data, 32'h2222_1111);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pair_wr_once", {31'b0, o_wr}, 32'd0);

    // Two back-to-back frames
    sreset();
    run_frame(16'd0, 16'd0, 16'd1, n_wr, n_fd, fd_idx, fd_data, first_data);
    chk("frm1_writes", 32'(n_wr), 32'd40);
    chk("frm1_fd_count", 32'(n_fd), 32'd1);
    chk("frm1_fd_index", 32'(fd_idx), 32'd40);
    chk("frm1_fd_data", fd_data, 32'h004F_004E);
    chk("frm1_first", first_data, 32'h0001_0000);
    run_frame(16'd80, 16'd80, 16'd81, n_wr, n_fd, fd_idx, fd_data, first_data);
    chk("frm2_writes", 32'(n_wr), 32'd40);
    chk("frm2_fd_count", 32'(n_fd), 32'd1);
    chk("frm2_fd_index", 32'(fd_idx), 32'd40);
    chk("frm2_fd_data", fd_data, 32'h009F_009E);

    // Backpressure: {B,A} held, {D,C} dropped
    cyc(1'b1, 16'hA0A0, 1'b1, 1'b0);
    cyc(1'b1, 16'hB0B0, 1'b1, 1'b0);
    cyc(1'b1, 16'hC0C0, 1'b1, 1'b0);
    chk("bp_no_wr_full", {31'b0, o_wr}, 32'd0);
    chk("bp_ovf_before", {31'b0, overflow}, 32'd0);
    cyc(1'b1, 16'hD0D0, 1'b1, 1'b0);
    chk("bp_overflow", {31'b0, overflow}, 32'd1);
    chk("bp_drop_cnt", {16'b0, drop_cnt}, CNT_EN ? 32'd1 : 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_release_wr", {31'b0, o_wr}, 32'd1);
    chk("bp_release_data", o_data, 32'hB0B0_A0A0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_dropped_gone", {31'b0, o_wr}, 32'd0);

    // Drop coincident with clear: drop wins
    cyc(1'b1, 16'hE0E0, 1'b1, 1'b0);
    cyc(1'b1, 16'hF0F0, 1'b1, 1'b0);
    cyc(1'b1, 16'h1010, 1'b1, 1'b0);
    cyc(1'b1, 16'h2020, 1'b1, 1'b1);
    chk("dc_overflow", {31'b0, overflow}, 32'd1);
    chk("dc_drop_cnt", {16'b0, drop_cnt}, CNT_EN ? 32'd1 : 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("dc_drain_data", o_data, 32'hF0F0_E0E0);
    chk("clr_overflow", {31'b0, overflow}, 32'd0);
    chk("clr_drop_cnt", {16'b0, drop_cnt}, 32'd0);

    // Sync reset mid-pair, then a fresh frame
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    sreset();
    run_frame(16'd0, 16'hAAAA, 16'hBBBB, n_wr, n_fd, fd_idx, fd_data, first_data);
    chk("srst_first_word", first_data, 32'hBBBB_AAAA);
    chk("srst_writes", 32'(n_wr), 32'd40);
    chk("srst_fd_index", 32'(fd_idx), 32'd40);
    chk("srst_fd_count", 32'(n_fd), 32'd1);

    // Async reset with a pending write and overflow set
    cyc(1'b1, 16'h0001, 1'b1, 1'b0);
    cyc(1'b1, 16'h0002, 1'b1, 1'b0);
    cyc(1'b1, 16'h0003, 1'b1, 1'b0);
    cyc(1'b1, 16'h0004, 1'b1, 1'b0);
    chk("arst_ovf_before", {31'b0, overflow}, 32'd1);
    smp_valid = 1'b1; smp_data = 16'h0005; fifo_full = 1'b0;
    #2;
    chk("arst_wr_before", {31'b0, fifo_wr_en}, 32'd1);
    rst_wr_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("arst_wr_data", fifo_wr_data, 32'd0);
    chk("arst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("arst_overflow", {31'b0, overflow}, 32'd0);
    chk("arst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    cyc(1'b1, 16'h5678, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("arst_next_word", o_data, 32'h5678_1234);
    chk("arst_next_wr", {31'b0, o_wr}, 32'd1);

    // Saturation of the 2-bit counter after 5 drops
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    chk("sat3_cnt2", {30'b0, s_drop_cnt}, CNT_EN ? 32'd3 : 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    chk("sat5_cnt2", {30'b0, s_drop_cnt}, CNT_EN ? 32'd3 : 32'd0);
    chk("sat5_ovf2", {31'b0, s_overflow}, 32'd1);
    chk("sat5_cnt16", {16'b0, drop_cnt}, CNT_EN ? 32'd5 : 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat_drain_data", o_data, 32'h0001_0000);

    chk("never_wr_while_full", 32'(full_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
